// File: rtl/my_dmux_pkg.sv
// Shared definitions for the two-channel 16-bit stream demultiplexer.
package my_dmux_pkg;

  localparam int unsigned WORD_W = 16;

  typedef enum logic {
    CH_A = 1'b0,
    CH_B = 1'b1
  } ch_sel_e;

endpackage

// File: rtl/my_fifo_16.sv
// Single-clock FIFO of 16-bit words; the head word is presented combinationally.
module my_fifo_16
  import my_dmux_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WORD_W-1:0]        push_data,
  input  logic                     pop,
  output logic [WORD_W-1:0]        head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   wptr_q, wptr_d;
  logic [PtrW-1:0]   rptr_q, rptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              push_en, pop_en;

  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);

  // Guard so a misbehaving caller can never over- or under-run the storage.
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_en) begin
      wptr_d = wptr_q + PtrW'(1);
    end
    if (pop_en) begin
      rptr_d = rptr_q + PtrW'(1);
    end
    unique case ({push_en, pop_en})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible once counted in.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem_q[wptr_q] <= push_data;
    end
  end

  assign head_data = mem_q[rptr_q];
  assign count     = count_q;

endmodule

// File: rtl/my_dmux_16_stream.sv
// Routes a valid/ready word stream into one of two independent output FIFOs.
module my_dmux_16_stream
  import my_dmux_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WORD_W-1:0]      in_data,
  input  logic                   in_sel,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [WORD_W-1:0]      a_data,
  output logic                   a_valid,
  input  logic                   a_ready,
  output logic [$clog2(DEPTH):0] a_count,
  output logic [WORD_W-1:0]      b_data,
  output logic                   b_valid,
  input  logic                   b_ready,
  output logic [$clog2(DEPTH):0] b_count
);

  ch_sel_e sel;
  logic    a_full, a_empty, b_full, b_empty;
  logic    sel_full, accept;
  logic    push_a, push_b, pop_a, pop_b;

  assign sel = ch_sel_e'(in_sel);

  // Readiness looks only at the selected FIFO's fill level, never at the consumer.
  always_comb begin
    sel_full = a_full;
    unique case (sel)
      CH_A:    sel_full = a_full;
      CH_B:    sel_full = b_full;
      default: sel_full = 1'b1;
    endcase
  end

  assign in_ready = !reset && !sel_full;
  assign accept   = in_valid && in_ready;
  assign push_a   = accept && (sel == CH_A);
  assign push_b   = accept && (sel == CH_B);

  assign a_valid = !a_empty;
  assign b_valid = !b_empty;
  assign pop_a   = a_valid && a_ready;
  assign pop_b   = b_valid && b_ready;

  my_fifo_16 #(
    .DEPTH (DEPTH)
  ) u_fifo_a (
    .clk       (clk),
    .reset     (reset),
    .push      (push_a),
    .push_data (in_data),
    .pop       (pop_a),
    .head_data (a_data),
    .count     (a_count),
    .full      (a_full),
    .empty     (a_empty)
  );

  my_fifo_16 #(
    .DEPTH (DEPTH)
  ) u_fifo_b (
    .clk       (clk),
    .reset     (reset),
    .push      (push_b),
    .push_data (in_data),
    .pop       (pop_b),
    .head_data (b_data),
    .count     (b_count),
    .full      (b_full),
    .empty     (b_empty)
  );

endmodule

// File: tb/tb_my_dmux_16_stream.sv
// Bench for my_dmux_16_stream: queue-based channel model plus directed literal scenarios.
module tb_my_dmux_16_stream;

  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          reset;
  logic [15:0]   in_data;
  logic          in_sel;
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   a_data;
  logic          a_valid;
  logic          a_ready;
  logic [CW-1:0] a_count;
  logic [15:0]   b_data;
  logic          b_valid;
  logic          b_ready;
  logic [CW-1:0] b_count;

  int vectors     = 0;
  int miscompares = 0;

  logic [15:0] qa[$];
  logic [15:0] qb[$];
  logic [15:0] got_a[$];
  logic [15:0] got_b[$];
  bit          log_en = 0;

  my_dmux_16_stream #(
    .DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_data   (a_data),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_count  (a_count),
    .b_data   (b_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_count  (b_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: two ordered queues; a word is taken when its queue has room before the edge.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      qa.delete();
      qb.delete();
    end else begin : upd
      int sa;
      int sb;
      bit acc;
      sa  = qa.size();
      sb  = qb.size();
      acc = in_valid && ((in_sel ? sb : sa) < DEPTH);
      if (sa > 0 && a_ready) void'(qa.pop_front());
      if (sb > 0 && b_ready) void'(qb.pop_front());
      if (acc) begin
        if (in_sel) qb.push_back(in_data);
        else        qa.push_back(in_data);
      end
    end
  end

  always @(negedge clk) begin : cmp
    bit exp_ready;
    exp_ready = !reset && ((in_sel ? qb.size() : qa.size()) < DEPTH);
    check("in_ready", 32'(in_ready), 32'(exp_ready));
    check("a_valid", 32'(a_valid), 32'(qa.size() > 0));
    check("b_valid", 32'(b_valid), 32'(qb.size() > 0));
    check("a_count", 32'(a_count), 32'(qa.size()));
    check("b_count", 32'(b_count), 32'(qb.size()));
    if (qa.size() > 0) check("a_data", 32'(a_data), 32'(qa[0]));
    if (qb.size() > 0) check("b_data", 32'(b_data), 32'(qb[0]));
    if (log_en) begin
      if (a_valid && a_ready) got_a.push_back(a_data);
      if (b_valid && b_ready) got_b.push_back(b_data);
    end
  end

  task automatic set_in(input bit v, input bit s, input logic [15:0] d, input bit ar,
                        input bit br);
    in_valid = v;
    in_sel   = s;
    in_data  = d;
    a_ready  = ar;
    b_ready  = br;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] exp_a[4];
    logic [15:0] exp_b[4];
    reset = 1'b1;
    set_in(0, 0, 16'h0, 0, 0);
    #2;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_a_valid", 32'(a_valid), 32'd0);
    check("rst_b_count", 32'(b_count), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    #1 check("post_rst_ready_a", 32'(in_ready), 32'd1);
    in_sel = 1'b1;
    #1 check("post_rst_ready_b", 32'(in_ready), 32'd1);

    // First word lands on channel a one edge after acceptance.
    set_in(1, 0, 16'b0000001010110010, 0, 0);
    tick();
    set_in(0, 0, 16'h0, 0, 0);
    check("t027_a_valid", 32'(a_valid), 32'd1);
    check("t027_a_data", 32'(a_data), 32'h02B2);
    check("t027_b_valid", 32'(b_valid), 32'd0);
    check("t027_a_count", 32'(a_count), 32'd1);
    set_in(0, 0, 16'h0, 1, 0);
    tick();

    // Fill b while its consumer stalls; a must still accept.
    set_in(1, 1, 16'b1100110011001100, 0, 0);
    tick();
    set_in(1, 1, 16'h00FF, 0, 0);
    tick();
    set_in(1, 1, 16'h5555, 0, 0);
    #1 check("t028_b_count", 32'(b_count), 32'd2);
    check("t028_ready_b", 32'(in_ready), 32'd0);
    in_sel = 1'b0;
    #1 check("t028_ready_a", 32'(in_ready), 32'd1);
    set_in(1, 0, 16'h1234, 0, 0);
    tick();
    check("t028_a_data", 32'(a_data), 32'h1234);
    check("t028_a_count", 32'(a_count), 32'd1);

    // Full b with its consumer ready: no pass-through, room appears next cycle.
    set_in(1, 1, 16'h5555, 0, 1);
    #1 check("t030_ready_full", 32'(in_ready), 32'd0);
    tick();
    check("t030_ready_after", 32'(in_ready), 32'd1);
    check("t030_b_count", 32'(b_count), 32'd1);
    check("t030_b_data", 32'(b_data), 32'h00FF);
    tick();
    check("t030_b_data2", 32'(b_data), 32'h5555);
    check("t030_b_count2", 32'(b_count), 32'd1);
    set_in(0, 0, 16'h0, 1, 1);
    tick();
    check("drain_a_count", 32'(a_count), 32'd0);
    check("drain_b_count", 32'(b_count), 32'd0);

    // Push and pop together at count 1.
    set_in(1, 0, 16'hAAAA, 0, 0);
    tick();
    set_in(1, 0, 16'hBBBB, 1, 0);
    tick();
    check("t031_a_data", 32'(a_data), 32'hBBBB);
    check("t031_a_valid", 32'(a_valid), 32'd1);
    check("t031_a_count", 32'(a_count), 32'd1);
    set_in(0, 0, 16'h0, 1, 1);
    tick();

    // Alternating stream with both consumers always ready.
    got_a.delete();
    got_b.delete();
    log_en = 1;
    for (int i = 1; i <= 8; i++) begin
      set_in(1, (i % 2) == 0, 16'(i), 1, 1);
      tick();
    end
    set_in(0, 0, 16'h0, 1, 1);
    tick();
    tick();
    log_en = 0;
    exp_a = '{16'd1, 16'd3, 16'd5, 16'd7};
    exp_b = '{16'd2, 16'd4, 16'd6, 16'd8};
    check("t029_a_n", 32'(got_a.size()), 32'd4);
    check("t029_b_n", 32'(got_b.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < got_a.size()) check("t029_a_word", 32'(got_a[i]), 32'(exp_a[i]));
      if (i < got_b.size()) check("t029_b_word", 32'(got_b[i]), 32'(exp_b[i]));
    end

    // Asynchronous reset mid-stream discards stored words.
    set_in(1, 0, 16'h1111, 0, 0);
    tick();
    set_in(1, 1, 16'h3333, 0, 0);
    tick();
    set_in(1, 0, 16'h2222, 0, 0);
    tick();
    set_in(0, 0, 16'h0, 0, 0);
    check("t032_a_count_pre", 32'(a_count), 32'd2);
    #1 reset = 1'b1;
    #1 check("t032_a_valid", 32'(a_valid), 32'd0);
    check("t032_a_count", 32'(a_count), 32'd0);
    check("t032_b_count", 32'(b_count), 32'd0);
    check("t032_ready", 32'(in_ready), 32'd0);
    #1 reset = 1'b0;
    set_in(1, 0, 16'h7777, 0, 0);
    tick();
    set_in(1, 0, 16'h8888, 0, 0);
    tick();
    check("t032_first", 32'(a_data), 32'h7777);
    check("t032_count", 32'(a_count), 32'd2);
    set_in(0, 0, 16'h0, 1, 0);
    tick();
    check("t032_second", 32'(a_data), 32'h8888);
    set_in(0, 0, 16'h0, 1, 1);
    tick();

    // Randomized traffic with occasional asynchronous reset pulses.
    for (int n = 0; n < 3000; n++) begin
      set_in($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), 16'($urandom),
             $urandom_range(0, 2) != 0, $urandom_range(0, 1) != 0);
      if ($urandom_range(0, 249) == 0) begin
        #1 reset = 1'b1;
        #1 reset = 1'b0;
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
